// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among NUM_REQ req/ack requesters.
// Latency: arbitration cycle to ack pulse is 2 cycles for writes, 3 for reads; one op in flight.
// Backpressure: requesters hold req until their ack; no arbitration happens until DONE returns to IDLE.
// Build option ARB_FIXED_PRIO_EN: lowest-index requester always wins and rr_ptr is removed.
module ram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic                          ram_cs_n,
  output logic                          ram_we_n,
  output logic                          ram_oe_n,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             op_we;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;

`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] op_idx;

  // Winner search: first asserted req at or above rr_ptr, wrapping to 0.
  always_comb begin : win_sel
    int cand;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_vld && req[IDX_W'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end
`else
  // Winner search: lowest-index asserted req (scan downward so the lowest overwrites last).
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[IDX_W'(i)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: writes skip CAPTURE since there is no data to return.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = op_we ? DONE : CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs: each output is loaded on the edge entering the state that shows it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      ram_cs_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_addr  <= '0;
      ram_wdata <= '0;
      op_we     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
      op_idx    <= '0;
`endif
    end else begin
      // Command and ack are single-cycle; fall back to idle unless set below.
      ack      <= '0;
      ram_cs_n <= 1'b1;
      ram_we_n <= 1'b1;
      ram_oe_n <= 1'b1;
      busy     <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (win_vld) begin
            // The RAM address/data registers double as the latched request.
            op_we    <= req_we[win_idx];
            gnt      <= NUM_REQ'(1) << win_idx;
            ram_cs_n <= 1'b0;
            ram_we_n <= ~req_we[win_idx];
            ram_oe_n <= req_we[win_idx];
            ram_addr <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            if (req_we[win_idx]) ram_wdata <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
`ifndef ARB_FIXED_PRIO_EN
            op_idx   <= win_idx;
`endif
          end
        end
        ISSUE: begin
          if (op_we) ack <= gnt;
        end
        CAPTURE: begin
          rdata <= ram_rdata;
          ack   <= gnt;
        end
        DONE: begin
          gnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
          if (op_idx == IDX_W'(NUM_REQ - 1)) rr_ptr <= '0;
          else                               rr_ptr <= op_idx + 1'b1;
`endif
        end
        default: gnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small behavioural synchronous RAM.
// Steps: reset, single write, read-back, wrap, reset mid-read, contention, idle.
// Outputs are sampled 1 time unit after each rising edge.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [15:0] rdata;
  logic        busy;
  logic        ram_cs_n;
  logic        ram_we_n;
  logic        ram_oe_n;
  logic [3:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  int passed = 0;
  int total  = 0;

  ram_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
    .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: writes land on the edge, reads return one cycle later.
  logic [15:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    ram_rdata = 16'h0;
  end
  always @(posedge clk) begin
    if (!ram_cs_n && !ram_we_n) mem[ram_addr] <= ram_wdata;
    if (!ram_cs_n && !ram_oe_n) ram_rdata <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Step until an ack appears (bounded); the acked requester drops req at once.
  task automatic wait_ack(output logic [3:0] who, output logic [15:0] rd);
    who = 4'h0;
    rd  = 16'h0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (ack != 4'h0) begin
        who = ack;
        rd  = rdata;
        req = req & ~ack;
        break;
      end
    end
  endtask

  logic [3:0]  who;
  logic [15:0] rd;
  logic [15:0] exp_rd [4];
  int          anomalies;

  initial begin
    rst = 1'b0; req = 4'h0; req_we = 4'h0; req_addr = 16'h0; req_wdata = 64'h0;
    repeat (3) step();
    chk("rst_gnt", gnt, 4'h0);
    chk("rst_ack", ack, 4'h0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd", {ram_cs_n, ram_we_n, ram_oe_n}, 3'b111);
    chk("rst_addr", ram_addr, 4'h0);
    chk("rst_wdata", ram_wdata, 16'h0);
    rst = 1'b1;
    step();

    // Single write from requester 1: this cycle is the arbitration cycle.
    req[1] = 1'b1; req_we[1] = 1'b1; req_addr[4 +: 4] = 4'h3; req_wdata[16 +: 16] = 16'hA5A5;
    step();  // ISSUE
    chk("wr_issue_cmd", {ram_cs_n, ram_we_n, ram_oe_n}, 3'b001);
    chk("wr_issue_addr", ram_addr, 4'h3);
    chk("wr_issue_wdata", ram_wdata, 16'hA5A5);
    chk("wr_issue_gnt", gnt, 4'b0010);
    chk("wr_issue_busy", busy, 1'b1);
    chk("wr_issue_ack", ack, 4'h0);
    step();  // DONE, 2 cycles after arbitration
    chk("wr_done_ack", ack, 4'b0010);
    chk("wr_done_cmd", {ram_cs_n, ram_we_n, ram_oe_n}, 3'b111);
    req[1] = 1'b0;
    step();  // IDLE
    chk("wr_idle_ack", ack, 4'h0);
    chk("wr_idle_gnt", gnt, 4'h0);
    chk("wr_idle_busy", busy, 1'b0);

    // Read back through requester 2.
    req[2] = 1'b1; req_we[2] = 1'b0; req_addr[8 +: 4] = 4'h3;
    step();  // ISSUE
    chk("rd_issue_cmd", {ram_cs_n, ram_we_n, ram_oe_n}, 3'b010);
    chk("rd_issue_gnt", gnt, 4'b0100);
    step();  // CAPTURE
    chk("rd_cap_ack", ack, 4'h0);
    chk("rd_cap_cmd", {ram_cs_n, ram_we_n, ram_oe_n}, 3'b111);
    chk("rd_cap_gnt", gnt, 4'b0100);
    step();  // DONE, 3 cycles after arbitration
    chk("rd_done_ack", ack, 4'b0100);
    chk("rd_done_rdata", rdata, 16'hA5A5);
    req[2] = 1'b0;
    step();  // IDLE
    chk("rd_idle_ack", ack, 4'h0);
    chk("rd_idle_rdata_hold", rdata, 16'hA5A5);

    // Wrap: rr_ptr is now 3, so requester 0 wins over 1.
    req_we = 4'b0011;
    req_addr[0 +: 4] = 4'h0; req_wdata[0 +: 16] = 16'h1111;
    req_addr[4 +: 4] = 4'h1; req_wdata[16 +: 16] = 16'h2222;
    req = 4'b0011;
    wait_ack(who, rd);
    chk("wrap_first", who, 4'b0001);
    wait_ack(who, rd);
    chk("wrap_second", who, 4'b0010);

    // Reset mid-read: requester 2 reads, reset lands in CAPTURE.
    req_we[2] = 1'b0; req_addr[8 +: 4] = 4'h0; req[2] = 1'b1;
    step();  // IDLE arbitration
    step();  // ISSUE
    chk("mr_issue_gnt", gnt, 4'b0100);
    step();  // CAPTURE
    rst = 1'b0;
    #1;
    chk("mr_gnt", gnt, 4'h0);
    chk("mr_ack", ack, 4'h0);
    chk("mr_rdata", rdata, 16'h0);
    chk("mr_cmd", {ram_cs_n, ram_we_n, ram_oe_n}, 3'b111);
    chk("mr_busy", busy, 1'b0);
    req = 4'h0;
    step();
    rst = 1'b1;
    step();
    chk("mr_post_ack", ack, 4'h0);

    // After reset rr_ptr is 0: requester 0 beats 3.
    req_we = 4'b1001;
    req_addr[0 +: 4] = 4'h2;  req_wdata[0 +: 16] = 16'h3333;
    req_addr[12 +: 4] = 4'h4; req_wdata[48 +: 16] = 16'h4444;
    req = 4'b1001;
    wait_ack(who, rd);
    chk("post_rst_first", who, 4'b0001);
    wait_ack(who, rd);
    chk("post_rst_second", who, 4'b1000);

    // Contention: all four read, rr_ptr back at 0, order 0,1,2,3.
    exp_rd[0] = 16'h1111; exp_rd[1] = 16'h2222; exp_rd[2] = 16'h3333; exp_rd[3] = 16'hA5A5;
    req_we = 4'b0000;
    req_addr = {4'h3, 4'h2, 4'h1, 4'h0};
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(who, rd);
      chk($sformatf("cont_gnt%0d", i), who, 4'b0001 << i);
      chk($sformatf("cont_rdata%0d", i), rd, exp_rd[i]);
    end

    // Idle: 20 cycles with no request.
    step();
    anomalies = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy !== 1'b0 || ram_cs_n !== 1'b1 || ack !== 4'h0) anomalies++;
    end
    chk("idle_anomalies", anomalies, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one port of the dual-port synchronous RAM between NUM_REQ requesters.
- Converts a simple req/ack handshake into the RAM's active-low cs/we/oe command encoding.
- Captures read data and returns it with a one-cycle ack pulse.
- Sits between bus-side masters (SPI/GPMC bridges, DMA engines) and the RAM port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 16, RAM data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request; held high until that requester's ack.
- req_we  input  NUM_REQ  per-requester op select: 1=write, 0=read; stable while req high.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- gnt  output  NUM_REQ  one-hot; identifies the requester being served.
- ack  output  NUM_REQ  one-cycle completion pulse to the served requester.
- rdata  output  DATA_WIDTH  read data; valid in the ack cycle of a read, held until next read completes.
- busy  output  1  high whenever state != IDLE.
- ram_cs_n  output  1  RAM chip select, active-low.
- ram_we_n  output  1  RAM write enable, active-low.
- ram_oe_n  output  1  RAM output enable, active-low.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_rdata  input  DATA_WIDTH  RAM registered read data; valid one cycle after a read command.

Behaviour:
- All outputs registered.
- Reset values: ram_cs_n=1, ram_we_n=1, ram_oe_n=1, ram_addr=0, ram_wdata=0, gnt=0, ack=0, rdata=0, busy=0, state=IDLE, rr_ptr=0.
- RAM command encoding:
  - write: cs_n=0, we_n=0, oe_n=1.
  - read: cs_n=0, we_n=1, oe_n=0.
  - idle: cs_n=1, we_n=1, oe_n=1.
  - Any other combination is never driven.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - If any req bit is high, select winner w by searching upward from rr_ptr with wrap (NUM_REQ-1 wraps to 0).
  - Latch req_we[w], addr and wdata of w; set gnt=one-hot(w); go to ISSUE.
  - No req: stay, outputs idle.
- ISSUE (exactly 1 cycle):
  - Drive the command for the latched op on ram_*.
  - Write -> DONE. Read -> CAPTURE.
- CAPTURE (reads only, 1 cycle):
  - RAM command returns to idle.
  - Register ram_rdata into rdata.
  - Go to DONE.
- DONE (1 cycle):
  - ack[w]=1.
  - rr_ptr <= (w+1) mod NUM_REQ.
  - gnt cleared on exit.
  - Go to IDLE.
- Latency from the IDLE arbitration cycle to the ack cycle: write = 2 cycles, read = 3 cycles.
- Maximum throughput: 1 write per 3 cycles, 1 read per 4 cycles.
- A requester samples ack at a clock edge and drops req on that same edge, so it is not re-granted in the following IDLE cycle.
- A back-to-back request from the same requester is allowed in the next IDLE cycle; it then loses to any other pending requester (round-robin).
- gnt is one-hot from the ISSUE cycle through DONE; zero otherwise.
- At most one RAM command per transaction; one transaction in flight.
- Requester inputs changing while granted are ignored, since values are latched in IDLE.
- req dropped before ack is a protocol violation; the arbiter still completes the op and pulses ack.
- Reset asserted mid-transaction: all outputs return to reset values immediately and no ack is issued. A write in the ISSUE cycle may or may not land in RAM.
- Simultaneous requests from all NUM_REQ requesters are served in strict rotation, with no starvation. Each requester waits at most NUM_REQ-1 transactions.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: winner is the lowest-index asserted req; rr_ptr is removed and stays unused. Starvation of high indices is permitted.
- Undefined: round-robin as above.
- Latencies and handshake are identical in both builds.

Test Plan:
- Single write: req[1]=1, we=1, addr=4'h3, wdata=16'hA5A5 -> ISSUE cycle shows cs_n=0, we_n=0, oe_n=1, addr=3, wdata=A5A5; ack[1] 2 cycles after arbitration.
- Read back: req[2]=1, we=0, addr=4'h3 -> ISSUE shows cs_n=0, we_n=1, oe_n=0; ack[2] 3 cycles after arbitration with rdata=16'hA5A5.
- Contention: req=4'b1111 held, each requester dropping its req after its ack, rr_ptr=0 -> grant order 0,1,2,3. With ARB_FIXED_PRIO_EN and req[0] re-asserted each time -> req[0] always wins.
- Wrap: rr_ptr=3 after serving requester 2, req=4'b0011 -> requester 0 granted, then requester 1.
- Reset mid-read: rst low during CAPTURE -> gnt=0, ack=0, rdata=0, cs_n/we_n/oe_n=1 immediately; after release, FSM in IDLE and rr_ptr=0.
- Idle: no req for 20 cycles -> busy=0, cs_n=1, no ack pulses.
